// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage core.
// Computes the ALU result, owns the N/C/V/Z flag register, resolves
// conditional branches against the current flags and drives the EX/MEM
// pipeline register. Zero bubbles from ID/EX pass through as no-ops.
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        hlt,
    input  logic        flush,
    input  logic [21:0] ex_pc,
    input  logic [31:0] s_data,
    input  logic [31:0] t_data,
    input  logic        use_imm,
    input  logic [16:0] imm,
    input  logic [2:0]  alu_opcode,
    input  logic        update_neg,
    input  logic        update_carry,
    input  logic        update_ov,
    input  logic        update_zero,
    input  logic [2:0]  branch_conditions,
    input  logic [4:0]  dst_reg,
    input  logic        use_dst_reg,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic        mem_alu_select,
    output logic        br_taken,
    output logic [21:0] br_target,
    output logic        flag_n,
    output logic        flag_c,
    output logic        flag_v,
    output logic        flag_z,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_store_data,
    output logic [4:0]  mem_dst_reg,
    output logic        mem_use_dst_reg,
    output logic        mem_mem_we,
    output logic        mem_mem_re,
    output logic        mem_mem_alu_select
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;

    logic [31:0] op_a, op_b, op_b_eff, alu_res;
    logic [32:0] sum;
    logic        res_c, res_v, cond_true, hold, is_arith;
    logic [4:0]  shamt;

    assign op_a      = s_data;
    assign op_b      = use_imm ? {{15{imm[16]}}, imm} : t_data;
    assign shamt     = op_b[4:0];
    // SUB reuses the adder as A + ~B + 1, so carry-out means "no borrow"
    assign op_b_eff  = (alu_opcode == OP_SUB) ? ~op_b : op_b;
    assign sum       = {1'b0, op_a} + {1'b0, op_b_eff} + {32'd0, (alu_opcode == OP_SUB)};
    assign is_arith  = (alu_opcode == OP_ADD) || (alu_opcode == OP_SUB);
    assign hold      = stall | hlt;

    // ALU result select
    always_comb begin
        alu_res = sum[31:0];
        case (alu_opcode)
            OP_ADD, OP_SUB: alu_res = sum[31:0];
            OP_AND:         alu_res = op_a & op_b;
            OP_OR:          alu_res = op_a | op_b;
            OP_XOR:         alu_res = op_a ^ op_b;
            OP_SLL:         alu_res = op_a << shamt;
            OP_SRL:         alu_res = op_a >> shamt;
            default:        alu_res = $unsigned($signed(op_a) >>> shamt);
        endcase
    end

    // Carry and signed overflow are only meaningful for the adder ops
    assign res_c = is_arith & sum[32];
    assign res_v = is_arith & (op_a[31] == op_b_eff[31]) & (sum[31] != op_a[31]);

    // Branch condition against the flags as they stand before this instruction
    always_comb begin
        cond_true = 1'b0;
        case (branch_conditions)
            3'b000: cond_true = 1'b0;
            3'b001: cond_true = flag_z;
            3'b010: cond_true = ~flag_z;
            3'b011: cond_true = flag_n ^ flag_v;
            3'b100: cond_true = ~(flag_n ^ flag_v);
            3'b101: cond_true = flag_c;
            3'b110: cond_true = 1'b1;
            default: cond_true = flag_n;
        endcase
    end

    assign br_taken  = cond_true & ~hold & ~flush;
    assign br_target = ex_pc + {{5{imm[16]}}, imm};

    // Flag register: written only by an advancing instruction, per enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
        end else if (!flush && !hold) begin
            if (update_neg)   flag_n <= alu_res[31];
            if (update_carry) flag_c <= res_c;
            if (update_ov)    flag_v <= res_v;
            if (update_zero)  flag_z <= (alu_res == 32'd0);
        end
    end

    // EX/MEM register: flush loads a bubble, stall/hlt hold, else advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_alu_result     <= 32'd0;
            mem_store_data     <= 32'd0;
            mem_dst_reg        <= 5'd0;
            mem_use_dst_reg    <= 1'b0;
            mem_mem_we         <= 1'b0;
            mem_mem_re         <= 1'b0;
            mem_mem_alu_select <= 1'b0;
        end else if (flush) begin
            mem_alu_result     <= 32'd0;
            mem_store_data     <= 32'd0;
            mem_dst_reg        <= 5'd0;
            mem_use_dst_reg    <= 1'b0;
            mem_mem_we         <= 1'b0;
            mem_mem_re         <= 1'b0;
            mem_mem_alu_select <= 1'b0;
        end else if (!hold) begin
            mem_alu_result     <= alu_res;
            mem_store_data     <= t_data;
            mem_dst_reg        <= dst_reg;
            mem_use_dst_reg    <= use_dst_reg;
            mem_mem_we         <= mem_we;
            mem_mem_re         <= mem_re;
            mem_mem_alu_select <= mem_alu_select;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed results; expected EX/MEM
// and flag state is queued at issue and checked by a separate monitor.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, hlt, flush, use_imm;
    logic [21:0] ex_pc;
    logic [31:0] s_data, t_data;
    logic [16:0] imm;
    logic [2:0]  alu_opcode, branch_conditions;
    logic        update_neg, update_carry, update_ov, update_zero;
    logic [4:0]  dst_reg;
    logic        use_dst_reg, mem_we, mem_re, mem_alu_select;
    logic        br_taken;
    logic [21:0] br_target;
    logic        flag_n, flag_c, flag_v, flag_z;
    logic [31:0] mem_alu_result, mem_store_data;
    logic [4:0]  mem_dst_reg;
    logic        mem_use_dst_reg, mem_mem_we, mem_mem_re, mem_mem_alu_select;

    int total = 0;
    int passed = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] sd;
        logic [4:0]  dst;
        logic [3:0]  ctl;    // use_dst, we, re, alu_select
        logic [3:0]  flags;  // n, c, v, z
    } exp_t;

    exp_t sbq[$];
    exp_t prev;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .hlt(hlt), .flush(flush),
        .ex_pc(ex_pc), .s_data(s_data), .t_data(t_data), .use_imm(use_imm),
        .imm(imm), .alu_opcode(alu_opcode), .update_neg(update_neg),
        .update_carry(update_carry), .update_ov(update_ov), .update_zero(update_zero),
        .branch_conditions(branch_conditions), .dst_reg(dst_reg),
        .use_dst_reg(use_dst_reg), .mem_we(mem_we), .mem_re(mem_re),
        .mem_alu_select(mem_alu_select), .br_taken(br_taken), .br_target(br_target),
        .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_dst_reg(mem_dst_reg), .mem_use_dst_reg(mem_use_dst_reg),
        .mem_mem_we(mem_mem_we), .mem_mem_re(mem_mem_re),
        .mem_mem_alu_select(mem_mem_alu_select)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: registered outputs are compared after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("mem_alu_result", mem_alu_result, e.res);
                chk("mem_store_data", mem_store_data, e.sd);
                chk("mem_ctl", {27'd0, mem_dst_reg, mem_use_dst_reg, mem_mem_we,
                                mem_mem_re, mem_mem_alu_select}, {27'd0, e.dst, e.ctl});
                chk("flags", {28'd0, flag_n, flag_c, flag_v, flag_z}, {28'd0, e.flags});
            end
        end
    end

    task automatic setin(input logic [2:0] op, input logic [31:0] a, input logic [31:0] t,
                         input logic ui, input logic [16:0] im, input logic [3:0] upd,
                         input logic [2:0] cond, input logic [21:0] pc);
        alu_opcode = op; s_data = a; t_data = t; use_imm = ui; imm = im;
        {update_neg, update_carry, update_ov, update_zero} = upd;
        branch_conditions = cond; ex_pc = pc;
        stall = 0; hlt = 0; flush = 0;
        dst_reg = 0; use_dst_reg = 0; mem_we = 0; mem_re = 0; mem_alu_select = 0;
    endtask

    // Check combinational branch outputs, queue the expected post-edge state
    task automatic issue(input logic [31:0] r, input logic [3:0] f,
                         input logic bt, input logic [21:0] tg);
        exp_t e;
        #1;
        chk("br_taken", {31'd0, br_taken}, {31'd0, bt});
        chk("br_target", {10'd0, br_target}, {10'd0, tg});
        if (flush) begin
            e = '0;
            e.flags = prev.flags;
        end else if (stall || hlt) begin
            e = prev;
        end else begin
            e.res = r; e.sd = t_data; e.dst = dst_reg;
            e.ctl = {use_dst_reg, mem_we, mem_re, mem_alu_select};
            e.flags = f;
        end
        sbq.push_back(e);
        prev = e;
        @(negedge clk);
        #1;
    endtask

    initial begin
        prev = '0;
        // Reset with random inputs
        rst_n = 0;
        setin(3'($urandom), $urandom, $urandom, 1'($urandom), 17'($urandom),
              4'($urandom), 3'($urandom), 22'($urandom));
        stall = 1'($urandom); dst_reg = 5'($urandom); use_dst_reg = 1; mem_we = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_alu_result", mem_alu_result, 32'd0);
        chk("rst_store_data", mem_store_data, 32'd0);
        chk("rst_ctl", {27'd0, mem_dst_reg, mem_use_dst_reg, mem_mem_we, mem_mem_re,
                        mem_mem_alu_select}, 32'd0);
        chk("rst_flags", {28'd0, flag_n, flag_c, flag_v, flag_z}, 32'd0);
        setin(3'd0, 0, 0, 0, 0, 4'b0000, 3'd0, 0);
        #1;
        chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
        rst_n = 1;

        // 1 bubble
        setin(3'd0, 0, 0, 0, 0, 4'b0000, 3'd0, 0);
        issue(32'd0, 4'b0000, 0, 22'd0);
        // 2 ADD overflow
        setin(3'd0, 32'h7FFFFFFF, 32'd1, 0, 0, 4'b1111, 3'd0, 22'h000100);
        dst_reg = 5'd3; use_dst_reg = 1;
        issue(32'h80000000, 4'b1010, 0, 22'h000100);
        // 3 AND updating N, branch on old N=1; target 0x10-4
        setin(3'd2, 32'hFFFF0000, 32'h0F0F0F0F, 0, 17'h1FFFC, 4'b1000, 3'd7, 22'h000010);
        issue(32'h0F0F0000, 4'b0010, 1, 22'h00000C);
        // 4 SUB 5-5 with immediate
        setin(3'd1, 32'd5, 32'hDEADBEEF, 1, 17'd5, 4'b0101, 3'd0, 22'h000020);
        mem_we = 1;
        issue(32'd0, 4'b0111, 0, 22'h000025);
        // 5 branch on Z, target wraps
        setin(3'd3, 32'h12, 32'h21, 0, 17'd4, 4'b0000, 3'd1, 22'h3FFFFE);
        issue(32'h33, 4'b0111, 1, 22'h000002);
        // 6 stall / hlt / stall with changing inputs and cond always
        setin(3'd0, 32'd9, 32'd9, 0, 17'd1, 4'b1111, 3'd6, 22'h000100);
        stall = 1; use_dst_reg = 1; mem_we = 1;
        issue(32'd0, 4'b0000, 0, 22'h000101);
        setin(3'd1, 32'd1, 32'd2, 0, 17'd2, 4'b1111, 3'd6, 22'h000200);
        hlt = 1; mem_re = 1;
        issue(32'd0, 4'b0000, 0, 22'h000202);
        setin(3'd4, 32'hAAAA, 32'h5555, 1, 17'd3, 4'b1111, 3'd6, 22'h000300);
        stall = 1; dst_reg = 5'd9;
        issue(32'd0, 4'b0000, 0, 22'h000303);
        // 7 release: SRA
        setin(3'd7, 32'h80000000, 32'd4, 0, 0, 4'b1000, 3'd2, 22'h000030);
        dst_reg = 5'd5; use_dst_reg = 1;
        issue(32'hF8000000, 4'b1111, 0, 22'h000030);
        // 8 SRL by immediate, cond !(N^V)
        setin(3'd6, 32'h80000000, 32'd0, 1, 17'd4, 4'b0001, 3'd4, 22'h000040);
        issue(32'h08000000, 4'b1110, 1, 22'h000044);
        // 9 SLL by 33 uses 1, cond C
        setin(3'd5, 32'h80000000, 32'd33, 0, 0, 4'b1111, 3'd5, 22'h000000);
        issue(32'd0, 4'b0001, 1, 22'h000000);
        // 10 flush + stall
        setin(3'd0, 32'd1, 32'd1, 0, 0, 4'b1111, 3'd6, 22'h000050);
        flush = 1; stall = 1; use_dst_reg = 1; mem_we = 1; dst_reg = 5'd7;
        issue(32'd0, 4'b0000, 0, 22'h000050);
        // 11 XOR, cond Z, negative imm target wraps
        setin(3'd4, 32'hFFFFFFFF, 32'h0000FFFF, 0, 17'h10000, 4'b1100, 3'd1, 22'h001000);
        mem_re = 1; mem_alu_select = 1;
        issue(32'hFFFF0000, 4'b1001, 1, 22'h3F1000);
        // 12 SUB borrow 0-1, cond N^V
        setin(3'd1, 32'd0, 32'd1, 0, 0, 4'b1111, 3'd3, 22'h000060);
        issue(32'hFFFFFFFF, 4'b1000, 1, 22'h000060);
        // 13 bubble
        setin(3'd0, 0, 0, 0, 0, 4'b0000, 3'd0, 0);
        issue(32'd0, 4'b1000, 0, 22'd0);

        // Reset asserted mid-stall clears immediately
        stall = 1; rst_n = 0;
        #1;
        chk("rst_mid_result", mem_alu_result, 32'd0);
        chk("rst_mid_flags", {28'd0, flag_n, flag_c, flag_v, flag_z}, 32'd0);
        rst_n = 1;
        prev = '0;
        // First instruction after release advances
        setin(3'd0, 32'd2, 32'd3, 0, 0, 4'b0001, 3'd6, 22'h000010);
        issue(32'd5, 4'b0000, 1, 22'h000010);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
